// File: rtl/gc_dram_pkg.sv
// Shared definitions for the GC-DRAM bank controller front end.
//   ADDR_W / DATA_W : flat row address and data word widths
//   BANK_W / ROW_W  : split of the flat address into bank and row fields
//   ref_state_t     : refresh arbiter state encoding
package gc_dram_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 64;
  localparam int BANK_W = 3;
  localparam int ROW_W  = 7;

  typedef enum logic [1:0] {
    IDLE,
    REF_RD,
    REF_WB
  } ref_state_t;

endpackage

// File: rtl/gc_refresh_arbiter_if.sv
// Host-side request/response bundle of the refresh arbiter.
//   host_we/host_waddr/host_wdata : write request, accepted when host_wready
//   host_re/host_raddr            : read request, accepted when host_rready
//   host_rvalid/host_rdata        : read response, one cycle after acceptance
// master = host, slave = arbiter.
interface gc_refresh_arbiter_if;
  import gc_dram_pkg::*;

  logic              host_we;
  logic [ADDR_W-1:0] host_waddr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_wready;
  logic              host_re;
  logic [ADDR_W-1:0] host_raddr;
  logic              host_rready;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  modport master (
    output host_we, host_waddr, host_wdata, host_re, host_raddr,
    input  host_wready, host_rready, host_rvalid, host_rdata
  );

  modport slave (
    input  host_we, host_waddr, host_wdata, host_re, host_raddr,
    output host_wready, host_rready, host_rvalid, host_rdata
  );

endinterface

// File: rtl/gc_refresh_timer.sv
// Refresh interval timer.
//   clk, rst : clock, synchronous active-high reset
//   en       : timer runs while high; held at its start value while low
//   clr      : restart the interval (a refresh has just been launched)
//   expire   : interval elapsed and timer enabled
// Implemented as a down-counter from INTERVAL-1 to a terminal count of zero,
// so cycles-remaining = INTERVAL-1 - (cycles counted since start).
module gc_refresh_timer #(
  parameter int INTERVAL = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int                CNT_W  = $clog2(INTERVAL);
  localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(INTERVAL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en || clr) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      // Saturate at terminal count; the arbiter always launches there.
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/gc_refresh_arbiter.sv
// Refresh arbiter: merges host reads/writes with periodic row refresh
// (read a row, write the returned data back) in front of the bank controller.
//   clk, rst            : clock, synchronous active-high reset
//   refresh_en          : enables the refresh interval timer
//   host (slave)        : host request/response bundle
//   we/waddr/wdata      : controller write port
//   re/raddr            : controller read port
//   rd                  : controller read data for the previous cycle's read
//   refresh_busy        : a refresh owns the controller ports
//   sweep_done          : one-cycle pulse after the last row is written back
//
// state  | meaning
// IDLE   | host passes straight through to the controller
// REF_RD | refresh reads row ref_ptr; host fully stalled
// REF_WB | refresh writes rd back to ref_ptr; host reads still allowed
module gc_refresh_arbiter
  import gc_dram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              refresh_en,
  gc_refresh_arbiter_if.slave host,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              re,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rd,
  output logic              refresh_busy,
  output logic              sweep_done
);

  ref_state_t        state_q;
  logic [ADDR_W-1:0] ref_ptr_q;
  logic              rvalid_q;
  logic              sweep_q;
  logic              tmr_expire;
  logic              tmr_clr;
  logic              wready;
  logic              rready;

  assign tmr_clr = (state_q == IDLE) && tmr_expire;

  gc_refresh_timer #(
    .INTERVAL (REFRESH_INTERVAL)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (refresh_en),
    .clr    (tmr_clr),
    .expire (tmr_expire)
  );

  always_comb begin
    we     = host.host_we;
    waddr  = host.host_waddr;
    wdata  = host.host_wdata;
    re     = host.host_re;
    raddr  = host.host_raddr;
    wready = 1'b1;
    rready = 1'b1;
    case (state_q)
      REF_RD: begin
        re     = 1'b1;
        raddr  = ref_ptr_q;
        we     = 1'b0;
        wready = 1'b0;
        rready = 1'b0;
      end
      REF_WB: begin
        we     = 1'b1;
        waddr  = ref_ptr_q;
        wdata  = rd;
        wready = 1'b0;
      end
      default: ;
    endcase
    // Reset must silence the controller immediately, even mid-refresh.
    if (rst) begin
      we     = 1'b0;
      re     = 1'b0;
      wready = 1'b0;
      rready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ref_ptr_q <= '0;
      rvalid_q  <= 1'b0;
      sweep_q   <= 1'b0;
    end else begin
      rvalid_q <= host.host_re && rready;
      sweep_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tmr_clr) begin
            state_q <= REF_RD;
          end
        end
        REF_RD: begin
          state_q <= REF_WB;
        end
        REF_WB: begin
          state_q   <= IDLE;
          ref_ptr_q <= ref_ptr_q + 1'b1;
          sweep_q   <= (ref_ptr_q == '1);
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign host.host_wready = wready;
  assign host.host_rready = rready;
  assign host.host_rvalid = rvalid_q;
  assign host.host_rdata  = rd;
  assign refresh_busy     = !rst && (state_q != IDLE);
  assign sweep_done       = sweep_q;

endmodule
